button_step_ctrl: RTL

//  Upstream conditioner for the wrapper_RISC `button` input.

---
 rtl/button_step_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/button_step_ctrl.sv
// button_step_ctrl: synchronises and debounces a raw push-button, then emits one-clock step pulses
// with optional auto-repeat, a debounced level and a press counter.
module button_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 0,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button_in,
    output logic               step_pulse,
    output logic               button_level,
    output logic [COUNT_W-1:0] press_count
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT = (REPEAT_CYCLES == 1) ? 2 : REPEAT_CYCLES;
    localparam int RW  = (RPT > 1) ? $clog2(RPT + 1) : 1;
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0]  RPT_LAST = RW'(RPT - 1);

    typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_t;

    state_t         state;
    logic           s1, s2;
    logic [DBW-1:0] db_cnt;
    logic [RW-1:0]  rpt_cnt;

    // db_cnt is always 0 in IDLE/PRESSED, so those states share the counting path of their debounce state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            state        <= IDLE;
            db_cnt       <= '0;
            rpt_cnt      <= '0;
            step_pulse   <= 1'b0;
            button_level <= 1'b0;
            press_count  <= '0;
        end else begin
            s1         <= button_in;
            s2         <= s1;
            step_pulse <= 1'b0;
            case (state)
                IDLE, DB_PRESS: begin
                    if (!s2) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state        <= PRESSED;
                        db_cnt       <= '0;
                        rpt_cnt      <= '0;
                        step_pulse   <= 1'b1;
                        button_level <= 1'b1;
                        press_count  <= press_count + 1'b1;
                    end else begin
                        state  <= DB_PRESS;
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                PRESSED, DB_RELEASE: begin
                    if (s2) begin
                        state  <= PRESSED;
                        db_cnt <= '0;
                        if (state == DB_RELEASE) begin
                            rpt_cnt <= '0;
                        end else if (RPT > 0) begin
                            if (rpt_cnt == RPT_LAST) begin
                                rpt_cnt     <= '0;
                                step_pulse  <= 1'b1;
                                press_count <= press_count + 1'b1;
                            end else begin
                                rpt_cnt <= rpt_cnt + 1'b1;
                            end
                        end
                    end else if (db_cnt == DB_LAST) begin
                        state        <= IDLE;
                        db_cnt       <= '0;
                        rpt_cnt      <= '0;
                        button_level <= 1'b0;
                    end else begin
                        state   <= DB_RELEASE;
                        db_cnt  <= db_cnt + 1'b1;
                        rpt_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
